simon_key_reverser: RTL and testbench
=====================================

Name: simon_key_reverser

Overview:
- Decryption-side round-key server for SIMON64/96; counterpart to the forward per-round key generator used by encryption.
- Accepts the 96-bit master key and expands it forward to the last three round keys, k39..k41.
- Then streams all 42 round keys in reverse order, k41 down to k0, one per accepted handshake.
- Sits between key load and the iterative decryption round datapath, so no 42×32 key RAM is needed.

Parameters:
- n, 32, word size in bits
- m, 3, number of key words
- T, 42, number of rounds and round keys

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- masterKey  in  96  {k2,k1,k0}; k0 = bits [31:0]
- busy  out  1  high in EXPAND and EMIT
- keyValid  out  1  roundKey is valid
- keyReady  in  1  consumer accepts roundKey
- roundKey  out  n  current round key, index roundIdx
- roundIdx  out  6  index of roundKey, 41..0
- lastKey  out  1  high with keyValid when roundIdx==0

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE; busy, keyValid and lastKey are 0; roundKey=0, roundIdx=0, window=0.
  - rst in any state, mid-expansion or mid-stream, aborts the operation with no further keys.
- Step function f(a,b,z) = a ^ C ^ z ^ ror3(b) ^ ror4(b).
  - C = 2^n-4 = 0xFFFFFFFC.
  - rorK means right circular rotate by K.
  - z is 1 bit, zero-extended to n bits.
- Z2: 62-bit constant; bit i = element i of the published z2 sequence. Only bits 0..38 are used.
- Window registers w0, w1, w2: three n-bit words.
- IDLE:
  - On start: w0=k0, w1=k1, w2=k2 from masterKey; cnt=0; go EXPAND.
  - start while busy is ignored.
- EXPAND (forward direction): each cycle {w0,w1,w2} <= {w1, w2, f(w0,w2,Z2[cnt])}; cnt++.
  - After the step with cnt==38 (39 steps total), the window holds k39, k40, k41.
  - Set roundIdx=41 and go EMIT.
  - keyValid first high in the cycle after the 39th edge following the start-sampling edge.
- EMIT:
  - Outputs: roundKey=w2, keyValid=1, lastKey=(roundIdx==0).
  - Outputs hold stable while keyValid && !keyReady.
  - On keyValid && keyReady: {w2,w1} <= {w1,w0}; roundIdx--.
    - If roundIdx>=3 (before decrement): w0 <= f(w2, w1, Z2[roundIdx-3]), which yields k[roundIdx-3]. This is the reverse recurrence k[i] = k[i+3] ^ C ^ z[i] ^ ror3(k[i+2]) ^ ror4(k[i+2]).
    - Otherwise w0 is held; its value is unused.
  - Handshake with roundIdx==0: go IDLE; keyValid, busy and lastKey drop on the next cycle.
- Throughput: one key per cycle while keyReady=1. No combinational path from keyReady to keyValid or roundKey.
- start asserted in the same cycle as the final handshake is ignored. start is accepted from the next IDLE cycle.
- All arithmetic is XOR/rotate on n bits. roundIdx never underflows.

Decomposition:
- Package simon64_96_pkg holds:
  - N=32, M=3, T=42
  - C_WORD=32'hFFFFFFFC
  - Z2 (62-bit)
  - state enum {IDLE, EXPAND, EMIT}
- Sub-module simon_key_step: combinational f(a,b,z); instantiated once and muxed between the EXPAND and EMIT operand sets.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release with start=0 → busy=0, keyValid=0, roundKey=0, roundIdx=0 indefinitely.
- Tail vector: masterKey=96'h13121110_0b0a0908_03020100, keyReady=1.
  - First keyValid exactly 39 edges after the start edge, with roundIdx=41.
  - 42 consecutive keys follow.
  - Final four keys: k3=0xFFAE9DCE, k2=0x13121110, k1=0x0b0a0908, k0=0x03020100.
  - lastKey only on k0; busy low one cycle later.
- Golden compare: 20 random master keys → the reversed stream equals a software forward SIMON64/96 schedule, reversed, for all 42 keys.
- Backpressure: keyReady toggled randomly at 50% → roundKey and roundIdx stable while stalled; no key dropped or duplicated; sequence is identical to the no-stall run.
- Abort: rst asserted at expansion step 20, and separately at roundIdx=17 → next cycle is IDLE with all outputs 0; a new start then produces a correct full stream.
- Start filtering: start pulsed during EXPAND, during EMIT, and on the final-handshake cycle → ignored; a start on the first IDLE cycle is accepted.

Source files
------------

// File: rtl/simon64_96_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : simon64_96_pkg
//  Purpose  : Shared constants and state encoding for the SIMON64/96 key server.
//  Revision : 1.0
// ============================================================================
package simon64_96_pkg;

    localparam int N = 32;
    localparam int M = 3;
    localparam int T = 42;

    localparam logic [N-1:0] C_WORD = 32'hFFFFFFFC;

    // Bit i holds element i of z2, so the literal reads last element first.
    localparam logic [61:0] Z2 =
        62'b11_0011011010_0111111000_1000010100_0110010010_1100000011_1011110101;

    localparam logic [5:0] EXPAND_LAST = 6'd38;
    localparam logic [5:0] LAST_IDX    = 6'(T - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/simon_key_step.sv
`default_nettype none
// ============================================================================
//  Module   : simon_key_step
//  Purpose  : Combinational key-schedule step a ^ C ^ z ^ ror3(b) ^ ror4(b).
//  Revision : 1.0
// ============================================================================
module simon_key_step
    import simon64_96_pkg::*;
(
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_z,
    output logic [N-1:0] o_f
);

    logic [N-1:0] w_ror3;
    logic [N-1:0] w_ror4;
    logic [N-1:0] w_zWord;

    assign w_ror3  = {i_b[2:0], i_b[N-1:3]};
    assign w_ror4  = {i_b[3:0], i_b[N-1:4]};
    assign w_zWord = {{(N-1){1'b0}}, i_z};
    assign o_f     = i_a ^ C_WORD ^ w_zWord ^ w_ror3 ^ w_ror4;

endmodule
`default_nettype wire

// File: rtl/simon_key_reverser.sv
`default_nettype none
// ============================================================================
//  Module   : simon_key_reverser
//  Purpose  : Expands a SIMON64/96 master key forward to k39..k41, then streams
//             round keys k41..k0 using the reverse schedule recurrence.
//  Revision : 1.0
// ============================================================================
module simon_key_reverser
    import simon64_96_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3*N-1:0] masterKey,
    output logic           busy,
    output logic           keyValid,
    input  logic           keyReady,
    output logic [N-1:0]   roundKey,
    output logic [5:0]     roundIdx,
    output logic           lastKey
);

    state_t       r_state;
    state_t       w_stateNext;
    logic [N-1:0] r_w0;
    logic [N-1:0] r_w1;
    logic [N-1:0] r_w2;
    logic [5:0]   r_cnt;
    logic [5:0]   r_roundIdx;

    logic [N-1:0] w_stepA;
    logic [N-1:0] w_stepB;
    logic [5:0]   w_zIdx;
    logic         w_stepZ;
    logic [N-1:0] w_stepOut;
    logic         w_handshake;
    logic         w_emitting;

    assign w_emitting  = (r_state == EMIT);
    assign w_handshake = w_emitting && keyReady;

    // One step unit: forward operands while expanding, reverse operands while emitting.
    always_comb begin
        w_stepA = r_w0;
        w_stepB = r_w2;
        w_zIdx  = r_cnt;
        if (w_emitting) begin
            w_stepA = r_w2;
            w_stepB = r_w1;
            w_zIdx  = (r_roundIdx >= 6'd3) ? (r_roundIdx - 6'd3) : 6'd0;
        end
        w_stepZ = Z2[w_zIdx];
    end

    simon_key_step u_step (
        .i_a (w_stepA),
        .i_b (w_stepB),
        .i_z (w_stepZ),
        .o_f (w_stepOut)
    );

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (start) w_stateNext = EXPAND;
            EXPAND:  if (r_cnt == EXPAND_LAST) w_stateNext = EMIT;
            EMIT:    if (keyReady && (r_roundIdx == 6'd0)) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_w0       <= '0;
            r_w1       <= '0;
            r_w2       <= '0;
            r_cnt      <= '0;
            r_roundIdx <= '0;
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_w0  <= masterKey[N-1:0];
                        r_w1  <= masterKey[2*N-1:N];
                        r_w2  <= masterKey[3*N-1:2*N];
                        r_cnt <= '0;
                    end
                end
                EXPAND: begin
                    r_w0  <= r_w1;
                    r_w1  <= r_w2;
                    r_w2  <= w_stepOut;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == EXPAND_LAST) r_roundIdx <= LAST_IDX;
                end
                EMIT: begin
                    if (w_handshake) begin
                        r_w2 <= r_w1;
                        r_w1 <= r_w0;
                        // Below index 3 the window already holds k2..k0; w0 is dead.
                        if (r_roundIdx >= 6'd3) r_w0 <= w_stepOut;
                        if (r_roundIdx != 6'd0) r_roundIdx <= r_roundIdx - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign keyValid = w_emitting;
    assign roundKey = w_emitting ? r_w2 : '0;
    assign roundIdx = r_roundIdx;
    assign lastKey  = w_emitting && (r_roundIdx == 6'd0);

endmodule
`default_nettype wire

// File: tb/tb_simon_key_reverser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simon_key_reverser
//  Purpose  : Directed self-checking bench for the SIMON64/96 reverse key server.
//  Revision : 1.0
// ============================================================================
module tb_simon_key_reverser;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        keyReady;
    logic [95:0] masterKey;
    logic        busy;
    logic        keyValid;
    logic        lastKey;
    logic [31:0] roundKey;
    logic [5:0]  roundIdx;

    int checks   = 0;
    int failures = 0;

    logic [31:0] expKeys [0:41];
    logic [31:0] gotKeys [0:41];

    always #5 clk = ~clk;

    simon_key_reverser dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .masterKey (masterKey),
        .busy      (busy),
        .keyValid  (keyValid),
        .keyReady  (keyReady),
        .roundKey  (roundKey),
        .roundIdx  (roundIdx),
        .lastKey   (lastKey)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int k);
        return (x >> k) | (x << (32 - k));
    endfunction

    // Forward SIMON64/96 schedule, z2 taken in published reading order.
    task automatic buildSchedule(input logic [95:0] key);
        string z2s = "10101111011100000011010010011000101000010001111110010110110011";
        logic [31:0] zw;
        expKeys[0] = key[31:0];
        expKeys[1] = key[63:32];
        expKeys[2] = key[95:64];
        for (int i = 3; i < 42; i++) begin
            zw = (z2s[i-3] == 8'h31) ? 32'd1 : 32'd0;
            expKeys[i] = ~expKeys[i-3] ^ 32'd3 ^ zw
                       ^ rotr(expKeys[i-1], 3) ^ rotr(expKeys[i-1], 4);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check(tag, {24'd0, busy, keyValid, lastKey, roundIdx, roundKey}, 64'd0);
    endtask

    // Starts on the current negedge and ends on the first negedge after the stream.
    task automatic runStream(input logic [95:0] key, input bit stall, input bit noisy);
        int lat;
        int idx;
        int cyc;
        bit stalled;
        logic [38:0] held;
        buildSchedule(key);
        masterKey = key;
        keyReady  = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!keyValid && lat < 100) begin
            start = noisy && (lat == 10);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'd39);
        idx = 41; stalled = 1'b0; cyc = 0; held = '0;
        while (idx >= 0 && cyc < 400) begin
            start = 1'b0;
            if (stalled) check("stall_hold", {25'd0, lastKey, roundIdx, roundKey}, {25'd0, held});
            keyReady = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noisy && keyReady && (idx == 20 || idx == 0)) start = 1'b1;
            if (keyReady) begin
                check($sformatf("key%0d", idx),
                      {24'd0, keyValid, lastKey, roundIdx, roundKey},
                      {24'd0, 1'b1, idx == 0, 6'(idx), expKeys[idx]});
                gotKeys[idx] = roundKey;
                idx--;
                stalled = 1'b0;
            end else begin
                held    = {lastKey, roundIdx, roundKey};
                stalled = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        keyReady = 1'b1;
        check("stream_end", 64'(idx + 1), 64'd0);
        check("idle_after", {61'd0, busy, keyValid, lastKey}, 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  sawValid;
        rst = 1'b1; start = 1'b0; keyReady = 1'b1; masterKey = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkAllZero("reset_idle");
            @(negedge clk);
        end

        // Published tail vector.
        runStream(96'h13121110_0b0a0908_03020100, 1'b0, 1'b0);
        check("tail_k3", 64'(gotKeys[3]), 64'hFFAE9DCE);
        check("tail_k2", 64'(gotKeys[2]), 64'h13121110);
        check("tail_k1", 64'(gotKeys[1]), 64'h0b0a0908);
        check("tail_k0", 64'(gotKeys[0]), 64'h03020100);

        // Additional directed keys, with and without backpressure.
        runStream(96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0, 1'b0);
        runStream(96'h00000000_00000000_00000000, 1'b1, 1'b0);
        runStream(96'h13121110_0b0a0908_03020100, 1'b1, 1'b0);
        runStream(96'hDEADBEEF_01234567_89ABCDEF, 1'b1, 1'b0);

        // Stray starts during EXPAND, EMIT and on the final handshake; then start on first IDLE cycle.
        runStream(96'hA5A5A5A5_5A5A5A5A_C3C3C3C3, 1'b0, 1'b1);
        runStream(96'h80000000_00000001_7FFFFFFF, 1'b0, 1'b0);

        // Abort in the middle of expansion.
        masterKey = 96'h11111111_22222222_33333333;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("abort_expand");
        sawValid = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (keyValid || busy) sawValid = 1'b1;
        end
        check("abort_expand_quiet", 64'(sawValid), 64'd0);
        runStream(96'h11111111_22222222_33333333, 1'b0, 1'b0);

        // Abort in the middle of the key stream.
        masterKey = 96'h0F0E0D0C_0B0A0908_07060504;
        keyReady  = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(keyValid && roundIdx == 6'd17) && cyc < 150) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_emit_reach", 64'(keyValid && roundIdx == 6'd17), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("abort_emit");
        @(negedge clk);
        checkAllZero("abort_emit_hold");
        runStream(96'h0F0E0D0C_0B0A0908_07060504, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
